write_data_pipe: RTL and testbench

Parametrised elastic register pipeline for the NMC write path: WIDTH-bit data words pass through DEPTH register stages with per-stage valid tracking, bubble collapsing, a global hold enable, flush and occupancy reporting. Sits between the write-command front end and the array write driver. It replaces single-bit enabled flops where multi-cycle, back-pressured write-data staging is needed.

---
 rtl/write_pipe_pkg.sv | 18 +
 rtl/write_pipe_stage.sv | 73 +++++++
 rtl/write_data_pipe.sv | 140 ++++++++++++++
 tb/tb_write_data_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_pipe_pkg.sv
// Shared definitions for the NMC write-data staging pipeline.
// Optional build macro: WRITE_PIPE_PARITY_EN (per-stage even-parity tracking).
package write_pipe_pkg;

  // Default geometry of the write-data pipe.
  localparam int WP_WIDTH  = 32;
  localparam int WP_DEPTH  = 4;

  // Widest data word the parity helper covers; narrower words are zero-extended,
  // which leaves the parity unchanged.
  localparam int PAR_MAX_W = 1024;

  // Even-parity bit: the value that makes data plus this bit hold an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] i_word);
    return ^i_word;
  endfunction

endpackage

// File: rtl/write_pipe_stage.sv
// One stage of the write-data pipe: a valid flag plus a data word that only
// loads on a transfer into the stage.
// Optional build macro: WRITE_PIPE_PARITY_EN adds a stored parity bit.
module write_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_data,
`ifdef WRITE_PIPE_PARITY_EN
  input  logic             i_par,
  output logic             o_par,
`endif
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
`ifdef WRITE_PIPE_PARITY_EN
  logic             r_par;
`endif

  // Valid flag: clear wins, then a refill, then an outbound move empties the slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      if (i_clr) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_adv) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  // Payload only changes when a word is transferred into this stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= {WIDTH{1'b0}};
`ifdef WRITE_PIPE_PARITY_EN
      r_par  <= 1'b0;
`endif
    end else if (i_en && i_load) begin
      r_data <= i_data;
`ifdef WRITE_PIPE_PARITY_EN
      r_par  <= i_par;
`endif
    end else begin
      r_data <= r_data;
`ifdef WRITE_PIPE_PARITY_EN
      r_par  <= r_par;
`endif
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
`ifdef WRITE_PIPE_PARITY_EN
  assign o_par   = r_par;
`endif

endmodule

// File: rtl/write_data_pipe.sv
// Elastic write-data pipeline: DEPTH stages with bubble collapsing, global hold,
// flush and a registered occupancy counter.
// Optional build macro: WRITE_PIPE_PARITY_EN enables per-word parity and a
// sticky par_err flag; without it par_err is constant 0.
module write_data_pipe
  import write_pipe_pkg::*;
#(
  parameter  int WIDTH = WP_WIDTH,
  parameter  int DEPTH = WP_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             sys_en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic             par_err
);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             w_accept;
  logic             w_deliver;
  logic [CNT_W-1:0] r_occ;
`ifdef WRITE_PIPE_PARITY_EN
  logic [DEPTH-1:0] w_par;
  logic             r_par_err;
`endif

  // Ready/advance chain walks from the output stage back to the input stage so a
  // stalled output still lets upstream words slide into empty slots.
  always_comb begin : adv_chain
    logic v_adv_dn;
    v_adv_dn         = w_valid[DEPTH-1] & out_ready & sys_en;
    w_adv            = {DEPTH{1'b0}};
    w_adv[DEPTH-1]   = v_adv_dn;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      v_adv_dn = w_valid[i] & (~w_valid[i+1] | v_adv_dn) & sys_en;
      w_adv[i] = v_adv_dn;
    end
  end

  assign in_ready  = sys_en & ~flush & ~rst & (~w_valid[0] | w_adv[0]);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = w_valid[DEPTH-1] & sys_en;
  assign out_data  = w_data[DEPTH-1];
  assign w_deliver = out_valid & out_ready;

  // Each stage refills from its upstream neighbour when that neighbour advances.
  always_comb begin
    w_load    = {DEPTH{1'b0}};
    w_load[0] = w_accept;
    for (int i = 1; i < DEPTH; i++) begin
      w_load[i] = w_adv[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_d_in;
`ifdef WRITE_PIPE_PARITY_EN
    logic             w_p_in;
`endif
    if (g == 0) begin : g_head
      assign w_d_in = in_data;
`ifdef WRITE_PIPE_PARITY_EN
      assign w_p_in = even_parity(PAR_MAX_W'(in_data));
`endif
    end else begin : g_body
      assign w_d_in = w_data[g-1];
`ifdef WRITE_PIPE_PARITY_EN
      assign w_p_in = w_par[g-1];
`endif
    end

    write_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clk   (sys_clk),
      .i_rst   (rst),
      .i_en    (sys_en),
      .i_clr   (flush),
      .i_load  (w_load[g]),
      .i_adv   (w_adv[g]),
      .i_data  (w_d_in),
`ifdef WRITE_PIPE_PARITY_EN
      .i_par   (w_p_in),
      .o_par   (w_par[g]),
`endif
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

  // Occupancy tracks accepts minus deliveries; flush empties the pipe outright.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_occ <= {CNT_W{1'b0}};
    end else if (sys_en) begin
      if (flush) begin
        r_occ <= {CNT_W{1'b0}};
      end else if (w_accept && !w_deliver) begin
        r_occ <= r_occ + CNT_W'(1);
      end else if (!w_accept && w_deliver) begin
        r_occ <= r_occ - CNT_W'(1);
      end else begin
        r_occ <= r_occ;
      end
    end else begin
      r_occ <= r_occ;
    end
  end

  assign occupancy = r_occ;

`ifdef WRITE_PIPE_PARITY_EN
  // Sticky parity alarm: re-check every delivered word; only reset clears it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_deliver && (even_parity(PAR_MAX_W'(out_data)) != w_par[DEPTH-1])) begin
      r_par_err <= 1'b1;
    end else begin
      r_par_err <= r_par_err;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_write_data_pipe.sv
// Bench for write_data_pipe (DEPTH=4, WIDTH=32). A queue model holding each
// word's stage position predicts in_ready, out_valid, out_data and occupancy on
// every falling edge; directed sequences add hand-computed literal checks.
module tb_write_data_pipe;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          sys_clk = 1'b0;
  logic          rst, sys_en, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, par_err;
  logic [W-1:0]  out_data;
  logic [CW-1:0] occupancy;

  int n_checks    = 0;
  int n_fail      = 0;
  int dut_deliv   = 0;
  int deliv_base  = 0;
  bit model_on    = 1'b0;
  bit data_chk_en = 1'b1;

  int           m_pos[$];
  logic [W-1:0] m_dat[$];

  write_data_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .sys_en    (sys_en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .par_err   (par_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Model: words in arrival order with their stage index. Each enabled cycle the
  // head may leave from the last stage; every other word steps forward one slot
  // but can never reach the slot of the word in front of it.
  always @(negedge sys_clk) begin
    int           np[$];
    logic [W-1:0] nd[$];
    int           lim;
    int           p;
    bit           e_ov, e_ir, dlv, s0_busy;
    np.delete();
    nd.delete();
    e_ov = sys_en && (m_pos.size() > 0) && (m_pos[0] == D - 1);
    dlv  = e_ov && out_ready;
    lim  = D - 1;
    for (int k = 0; k < m_pos.size(); k++) begin
      if (!(k == 0 && dlv)) begin
        p = m_pos[k];
        if (sys_en) p = (p + 1 < lim) ? p + 1 : lim;
        np.push_back(p);
        nd.push_back(m_dat[k]);
        lim = p - 1;
      end
    end
    s0_busy = 1'b0;
    if (np.size() > 0) s0_busy = (np[np.size()-1] == 0);
    e_ir = sys_en && !flush && !rst && !s0_busy;
    if (model_on) begin
      chk("in_ready", in_ready, e_ir);
      chk("out_valid", out_valid, e_ov);
      chk("occupancy", occupancy, m_pos.size());
      if (e_ov && data_chk_en) chk("out_data", out_data, m_dat[0]);
`ifndef WRITE_PIPE_PARITY_EN
      chk("par_err", par_err, 0);
`endif
      if (out_valid && out_ready) dut_deliv++;
    end
    if (e_ir && in_valid) begin
      np.push_back(0);
      nd.push_back(in_data);
    end
    if (rst || (sys_en && flush)) begin
      np.delete();
      nd.delete();
    end
    m_pos = np;
    m_dat = nd;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sys_en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    model_on = 1'b1;
    rst = 1'b0;
    #1;
    chk("reset_occ", occupancy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 1);

    // Back-to-back stream with the output always ready.
    out_ready = 1'b1;
    deliv_base = dut_deliv;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA5A5_0000 + 32'(i);
      tick();
      if (i == 4) begin
        chk("latency_valid", out_valid, 1);
        chk("latency_data", out_data, 32'hA5A5_0001);
      end
      if (i >= 4) chk("stream_occ", occupancy, 4);
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stream_drained", occupancy, 0);
    chk("stream_count", dut_deliv - deliv_base, 8);

    // Back-pressure: fill with the output blocked, then release it.
    out_ready = 1'b0;
    deliv_base = dut_deliv;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hB000_0000 + 32'(i);
      tick();
    end
    in_data = 32'hB000_0005;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_occ", occupancy, 4);
    tick();
    chk("full_hold_occ", occupancy, 4);
    out_ready = 1'b1;
    #1;
    chk("full_passthru_ready", in_ready, 1);
    tick();
    chk("full_swap_occ", occupancy, 4);
    in_valid = 1'b0;
    repeat (6) tick();
    chk("full_count", dut_deliv - deliv_base, 5);

    // Sparse input with a two-cycle output stall: bubbles collapse.
    deliv_base = dut_deliv;
    for (int c = 0; c < 16; c++) begin
      in_valid  = (c % 2 == 0);
      in_data   = 32'hC000_0000 + 32'(c);
      out_ready = !(c == 3 || c == 4);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("bubble_count", dut_deliv - deliv_base, 8);

    // Global hold with a full pipe (flush during hold is ignored).
    out_ready = 1'b0;
    deliv_base = dut_deliv;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hD000_0000 + 32'(i);
      tick();
    end
    sys_en = 1'b0;
    in_data = 32'hD000_00FF;
    out_ready = 1'b1;
    #1;
    chk("hold_out_valid", out_valid, 0);
    chk("hold_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      tick();
      chk("hold_occ", occupancy, 4);
    end
    sys_en = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("resume_valid", out_valid, 1);
    chk("resume_data", out_data, 32'hD000_0001);
    repeat (6) tick();
    chk("resume_count", dut_deliv - deliv_base, 4);

    // Flush with three words held.
    out_ready = 1'b0;
    deliv_base = dut_deliv;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hE000_0000 + 32'(i);
      tick();
    end
    chk("preflush_occ", occupancy, 3);
    flush = 1'b1;
    in_data = 32'hE000_0004;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_occ", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("flush_count", dut_deliv - deliv_base, 0);

    // Reset in the middle of a stream drops everything.
    deliv_base = dut_deliv;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hF000_0000 + 32'(i);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("post_rst_count", dut_deliv - deliv_base, 1);

`ifdef WRITE_PIPE_PARITY_EN
    // Corrupt the word sitting in stage 2 and watch the sticky alarm.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h7000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    data_chk_en = 1'b0;
    chk("par_clean", par_err, 0);
    force dut.g_stage[2].u_stage.r_data = 32'h7000_0003;
    #1;
    release dut.g_stage[2].u_stage.r_data;
    out_ready = 1'b1;
    tick();
    tick();
    chk("par_set", par_err, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("par_after_flush", par_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("par_after_rst", par_err, 0);
    data_chk_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
